// File: rtl/fifo_ctrl_pkg.sv
// Shared width defaults for the main queue: pointer controller, RAM and wrapper all
// take their MAIN_QUEUE_SIZE / DATA_SIZE defaults from here so they cannot diverge.
package fifo_ctrl_pkg;

  localparam int unsigned MAIN_QUEUE_SIZE_DEF = 3;
  localparam int unsigned DATA_SIZE_DEF       = 6;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Handshake/status bundle between the queue wrapper and the pointer/flag controller.
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned MAIN_QUEUE_SIZE = MAIN_QUEUE_SIZE_DEF
);

  localparam int unsigned CW = MAIN_QUEUE_SIZE + 1;

  logic                       push;
  logic                       pop;
  logic [CW-1:0]              thr_almost_full;
  logic [CW-1:0]              thr_almost_empty;
  logic                       write;
  logic                       read;
  logic [MAIN_QUEUE_SIZE-1:0] wr_ptr;
  logic [MAIN_QUEUE_SIZE-1:0] rd_ptr;
  logic [CW-1:0]              count;
  logic                       full;
  logic                       empty;
  logic                       almost_full;
  logic                       almost_empty;
  logic                       error;

  modport master (
    output push, pop, thr_almost_full, thr_almost_empty,
    input  write, read, wr_ptr, rd_ptr, count,
    input  full, empty, almost_full, almost_empty, error
  );

  modport slave (
    input  push, pop, thr_almost_full, thr_almost_empty,
    output write, read, wr_ptr, rd_ptr, count,
    output full, empty, almost_full, almost_empty, error
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping RAM address counter with enable; wraps modulo 2**WIDTH by natural overflow.
module fifo_ptr #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + WIDTH'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for the main queue RAM. Data never passes
// through here; write/read are the RAM enables for accepted push/pop.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned MAIN_QUEUE_SIZE = MAIN_QUEUE_SIZE_DEF,
  parameter int unsigned DATA_SIZE       = DATA_SIZE_DEF
) (
  input  logic       clk,
  input  logic       reset_L,
  fifo_ctrl_if.slave bus
);

  localparam int unsigned  AW    = MAIN_QUEUE_SIZE;
  localparam int unsigned  CW    = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1) << AW;

  // DATA_SIZE only describes the neighbouring RAM; reject nonsensical configurations.
  if (DATA_SIZE == 0 || MAIN_QUEUE_SIZE == 0) begin : g_bad_cfg
    $error("fifo_ctrl: DATA_SIZE and MAIN_QUEUE_SIZE must be non-zero");
  end

  logic [CW-1:0] r_count;
  logic          r_error;
  logic          w_full;
  logic          w_empty;
  logic          w_pop_ok;
  logic          w_push_ok;
  logic          w_overflow;
  logic          w_underflow;
  logic [AW-1:0] w_wr_ptr;
  logic [AW-1:0] w_rd_ptr;

  // Acceptance from registered occupancy; a pop frees the slot a same-cycle push needs.
  always_comb begin
    w_full      = (r_count == DEPTH);
    w_empty     = (r_count == '0);
    w_pop_ok    = bus.pop & ~w_empty;
    w_push_ok   = bus.push & (~w_full | w_pop_ok);
    w_overflow  = bus.push & w_full & ~w_pop_ok;
    w_underflow = bus.pop & w_empty;
  end

  fifo_ptr #(.WIDTH(AW)) u_wr_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .i_en    (w_push_ok),
    .o_ptr   (w_wr_ptr)
  );

  fifo_ptr #(.WIDTH(AW)) u_rd_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .i_en    (w_pop_ok),
    .o_ptr   (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_overflow || w_underflow) begin
        r_error <= 1'b1;
      end
    end
  end

  // RAM enables are gated by reset so nothing is written while reset_L is low.
  assign bus.write        = w_push_ok & reset_L;
  assign bus.read         = w_pop_ok & reset_L;
  assign bus.wr_ptr       = w_wr_ptr;
  assign bus.rd_ptr       = w_rd_ptr;
  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= bus.thr_almost_full);
  assign bus.almost_empty = (r_count <= bus.thr_almost_empty);
  assign bus.error        = r_error;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a queue-of-tags reference model plus a bench-side
// RAM, so pointer mistakes show up as wrong data order as well as wrong addresses.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int unsigned AW    = 3;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  fifo_ctrl_if #(.MAIN_QUEUE_SIZE(AW)) bus ();

  fifo_ctrl #(.MAIN_QUEUE_SIZE(AW), .DATA_SIZE(6)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // Bench-side storage driven by the DUT's enables and addresses.
  logic [5:0] ram [DEPTH];
  logic [5:0] wdata;
  always @(posedge clk) if (bus.write) ram[bus.wr_ptr] <= wdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: queue contents plus running totals of accepted ops.
  int          mq[$];
  int unsigned m_wr = 0;
  int unsigned m_rd = 0;
  bit          m_err = 1'b0;

  // Observations of the last step (pre-edge) and the model's expectations for them.
  logic          o_w, o_r;
  logic [5:0]    o_d;
  logic [AW-1:0] o_wp, o_rp;
  bit            e_w, e_r;
  int            e_d;

  task automatic step(input bit p, input bit q);
    bus.push = p;
    bus.pop  = q;
    wdata    = 6'($urandom);
    #1;
    o_w  = bus.write;
    o_r  = bus.read;
    o_d  = ram[bus.rd_ptr];
    o_wp = bus.wr_ptr;
    o_rp = bus.rd_ptr;
    e_r  = reset_L && q && (mq.size() > 0);
    e_w  = reset_L && p && ((mq.size() < DEPTH) || e_r);
    e_d  = (mq.size() > 0) ? mq[0] : 0;
    @(posedge clk);
    if (!reset_L) begin
      mq.delete();
      m_wr  = 0;
      m_rd  = 0;
      m_err = 1'b0;
    end else begin
      if (q && mq.size() == 0) m_err = 1'b1;
      if (p && mq.size() == DEPTH && !e_r) m_err = 1'b1;
      if (e_r) begin void'(mq.pop_front()); m_rd++; end
      if (e_w) begin mq.push_back(int'(wdata)); m_wr++; end
    end
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    step(1'b0, 1'b0);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    bus.thr_almost_full  = '0;
    bus.thr_almost_empty = CW'(2);
    step(1'b1, 1'b1);
    n_vec++; if (o_w !== 1'b0) begin n_err++; $display("FAIL reset_write: got %b want 0", o_w); end
    n_vec++; if (o_r !== 1'b0) begin n_err++; $display("FAIL reset_read: got %b want 0", o_r); end
    n_vec++; if (bus.count !== CW'(0)) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.wr_ptr !== AW'(0) || bus.rd_ptr !== AW'(0)) begin n_err++; $display("FAIL reset_ptrs: got wr=%0d rd=%0d want 0/0", bus.wr_ptr, bus.rd_ptr); end
    n_vec++; if ({bus.empty, bus.full, bus.error} !== 3'b100) begin n_err++; $display("FAIL reset_flags: got e/f/err=%b want 100", {bus.empty, bus.full, bus.error}); end
    n_vec++; if ({bus.almost_empty, bus.almost_full} !== 2'b11) begin n_err++; $display("FAIL reset_almost_thr0: got ae/af=%b want 11", {bus.almost_empty, bus.almost_full}); end
    bus.thr_almost_full = CW'(4);
    #1;
    n_vec++; if (bus.almost_full !== 1'b0) begin n_err++; $display("FAIL reset_almost_full_thr4: got %b want 0", bus.almost_full); end
    reset_L = 1'b1;
  endtask

  task automatic test_fill();
    bus.thr_almost_full = CW'(6);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      n_vec++; if (o_w !== 1'b1 || o_wp !== AW'(i)) begin n_err++; $display("FAIL fill_write[%0d]: got w=%b wr_ptr=%0d want 1/%0d", i, o_w, o_wp, i); end
      n_vec++; if (bus.count !== CW'(mq.size())) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, mq.size()); end
      n_vec++; if (bus.almost_full !== (mq.size() >= 6) || bus.full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL fill_flags[%0d]: got af/full=%b%b want %b%b", i, bus.almost_full, bus.full, mq.size() >= 6, mq.size() == DEPTH); end
    end
    n_vec++; if (bus.wr_ptr !== AW'(0) || bus.error !== 1'b0) begin n_err++; $display("FAIL fill_wrap: got wr_ptr=%0d err=%b want 0/0", bus.wr_ptr, bus.error); end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0);
    n_vec++; if (o_w !== 1'b0) begin n_err++; $display("FAIL ovf_write: got %b want 0", o_w); end
    n_vec++; if (bus.count !== CW'(8) || bus.error !== 1'b1 || bus.wr_ptr !== AW'(0)) begin n_err++; $display("FAIL ovf_state: got cnt=%0d err=%b wr=%0d want 8/1/0", bus.count, bus.error, bus.wr_ptr); end
    step(1'b1, 1'b1);
    n_vec++; if (o_w !== 1'b1 || o_r !== 1'b1) begin n_err++; $display("FAIL full_pushpop_en: got w/r=%b%b want 11", o_w, o_r); end
    n_vec++; if (o_d !== 6'(e_d)) begin n_err++; $display("FAIL full_pushpop_data: got %0d want %0d", o_d, e_d); end
    n_vec++; if (bus.count !== CW'(8) || bus.rd_ptr !== AW'(1) || bus.wr_ptr !== AW'(1)) begin n_err++; $display("FAIL full_pushpop_state: got cnt=%0d rd=%0d wr=%0d want 8/1/1", bus.count, bus.rd_ptr, bus.wr_ptr); end
  endtask

  task automatic test_drain();
    bus.thr_almost_empty = CW'(2);
    for (int i = 0; i < 8 && mq.size() > 0; i++) begin
      step(1'b0, 1'b1);
      n_vec++; if (o_r !== 1'b1 || o_d !== 6'(e_d)) begin n_err++; $display("FAIL drain_read[%0d]: got r=%b d=%0d want 1/%0d", i, o_r, o_d, e_d); end
      n_vec++; if (bus.almost_empty !== (mq.size() <= 2) || bus.count !== CW'(mq.size())) begin n_err++; $display("FAIL drain_state[%0d]: got ae=%b cnt=%0d want %b/%0d", i, bus.almost_empty, bus.count, mq.size() <= 2, mq.size()); end
    end
    step(1'b0, 1'b1);
    n_vec++; if (o_r !== 1'b0) begin n_err++; $display("FAIL udf_read: got %b want 0", o_r); end
    n_vec++; if (bus.count !== CW'(0) || bus.empty !== 1'b1 || bus.error !== 1'b1) begin n_err++; $display("FAIL udf_state: got cnt=%0d empty=%b err=%b want 0/1/1", bus.count, bus.empty, bus.error); end
  endtask

  task automatic test_empty_pushpop();
    logic [AW-1:0] wp0, rp0;
    do_reset();
    wp0 = bus.wr_ptr;
    rp0 = bus.rd_ptr;
    step(1'b1, 1'b1);
    n_vec++; if (o_w !== 1'b1 || o_r !== 1'b0) begin n_err++; $display("FAIL empty_pushpop_en: got w/r=%b%b want 10", o_w, o_r); end
    n_vec++; if (bus.count !== CW'(1) || bus.wr_ptr !== AW'(wp0 + 1) || bus.rd_ptr !== rp0 || bus.error !== 1'b1) begin n_err++; $display("FAIL empty_pushpop_state: got cnt=%0d wr=%0d rd=%0d err=%b want 1/%0d/%0d/1", bus.count, bus.wr_ptr, bus.rd_ptr, bus.error, AW'(wp0 + 1), rp0); end
    step(1'b0, 1'b1);
    n_vec++; if (o_r !== 1'b1 || o_d !== 6'(e_d)) begin n_err++; $display("FAIL empty_pushpop_data: got r=%b d=%0d want 1/%0d", o_r, o_d, e_d); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    n_vec++; if (bus.count !== CW'(5) || bus.error !== 1'b1) begin n_err++; $display("FAIL mid_prefill: got cnt=%0d err=%b want 5/1", bus.count, bus.error); end
    reset_L = 1'b0;
    step(1'b1, 1'b0);
    n_vec++; if (o_w !== 1'b0) begin n_err++; $display("FAIL mid_reset_write: got %b want 0", o_w); end
    n_vec++; if (bus.count !== CW'(0) || bus.wr_ptr !== AW'(0) || bus.rd_ptr !== AW'(0) || bus.error !== 1'b0) begin n_err++; $display("FAIL mid_reset_state: got cnt=%0d wr=%0d rd=%0d err=%b want 0/0/0/0", bus.count, bus.wr_ptr, bus.rd_ptr, bus.error); end
    reset_L = 1'b1;
  endtask

  task automatic test_random();
    int unsigned push_pct;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) push_pct = $urandom_range(85, 15);
      if (i % 16 == 0) begin
        bus.thr_almost_full  = CW'($urandom_range(DEPTH, 0));
        bus.thr_almost_empty = CW'($urandom_range(DEPTH, 0));
      end
      reset_L = ($urandom_range(199, 0) != 0);
      step($urandom_range(99, 0) < push_pct, $urandom_range(99, 0) < (100 - push_pct));
      n_vec++; if (o_w !== e_w || o_r !== e_r) begin n_err++; $display("FAIL rnd_en[%0d]: got w/r=%b%b want %b%b", i, o_w, o_r, e_w, e_r); end
      if (e_r) begin
        n_vec++; if (o_d !== 6'(e_d)) begin n_err++; $display("FAIL rnd_data[%0d]: got %0d want %0d", i, o_d, e_d); end
      end
      n_vec++; if (bus.count !== CW'(mq.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, bus.count, mq.size()); end
      n_vec++; if (bus.wr_ptr !== AW'(m_wr % DEPTH) || bus.rd_ptr !== AW'(m_rd % DEPTH)) begin n_err++; $display("FAIL rnd_ptrs[%0d]: got wr=%0d rd=%0d want %0d/%0d", i, bus.wr_ptr, bus.rd_ptr, m_wr % DEPTH, m_rd % DEPTH); end
      n_vec++; if (bus.full !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0)) begin n_err++; $display("FAIL rnd_fe[%0d]: got full/empty=%b%b size=%0d", i, bus.full, bus.empty, mq.size()); end
      n_vec++; if (bus.almost_full !== (mq.size() >= int'(bus.thr_almost_full)) || bus.almost_empty !== (mq.size() <= int'(bus.thr_almost_empty))) begin n_err++; $display("FAIL rnd_almost[%0d]: got af/ae=%b%b size=%0d thr=%0d/%0d", i, bus.almost_full, bus.almost_empty, mq.size(), bus.thr_almost_full, bus.thr_almost_empty); end
      n_vec++; if (bus.error !== m_err) begin n_err++; $display("FAIL rnd_error[%0d]: got %b want %b", i, bus.error, m_err); end
    end
    reset_L = 1'b1;
  endtask

  initial begin
    bus.push             = 1'b0;
    bus.pop              = 1'b0;
    bus.thr_almost_full  = CW'(6);
    bus.thr_almost_empty = CW'(2);
    wdata                = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_empty_pushpop();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for the main queue.
- Sits directly upstream of the queue's RAM storage and drives its write/read enables and write/read addresses.
- Tracks occupancy, raises full/empty and programmable almost-full/almost-empty flags, and flags overflow/underflow.
- A queue wrapper instantiates this block next to the RAM; data never passes through this block.

Parameters:
- MAIN_QUEUE_SIZE, 3, address width; queue depth DEPTH = 2**MAIN_QUEUE_SIZE (8 by default).
- DATA_SIZE, 6, width of the neighbouring RAM word; carried for wrapper consistency only, not used internally.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_L  in  1  synchronous, active-low reset.
- push  in  1  upstream write request.
- pop  in  1  downstream read request.
- thr_almost_full  in  MAIN_QUEUE_SIZE+1  almost-full threshold (count units).
- thr_almost_empty  in  MAIN_QUEUE_SIZE+1  almost-empty threshold (count units).
- write  out  1  RAM write enable (accepted push).
- read  out  1  RAM read enable (accepted pop); RAM data is valid in the same cycle.
- wr_ptr  out  MAIN_QUEUE_SIZE  RAM write address.
- rd_ptr  out  MAIN_QUEUE_SIZE  RAM read address.
- count  out  MAIN_QUEUE_SIZE+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= thr_almost_full.
- almost_empty  out  1  count <= thr_almost_empty.
- error  out  1  sticky overflow/underflow indicator.

Behaviour:
- Reset (clk edge with reset_L=0):
  - wr_ptr=0, rd_ptr=0, count=0, error=0.
  - Resulting flags: empty=1, full=0; almost_empty = (0 <= thr_almost_empty) = 1; almost_full = (0 >= thr_almost_full), which is 1 only if the threshold is 0.
  - Reset overrides any push/pop in the same cycle.
  - While reset_L=0, write=0 and read=0 combinationally, so the RAM is never written during reset.
- Acceptance (combinational, from registered state):
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok).
  - write = push_ok & reset_L; read = pop_ok & reset_L.
- Latency:
  - Accepted push writes the RAM at the same clk edge; its data can be popped from the next cycle.
  - Accepted pop presents ram[rd_ptr] combinationally that cycle; rd_ptr advances at the edge.
- Pointer update on clk edge:
  - wr_ptr += push_ok; rd_ptr += pop_ok.
  - Both pointers wrap modulo DEPTH (natural MAIN_QUEUE_SIZE-bit overflow; 7 -> 0 at default).
- Count update:
  - count += 1 on push_ok only; count -= 1 on pop_ok only.
  - Unchanged when neither or both are accepted.
  - Never exceeds DEPTH and never goes below 0.
- Flags: combinational decodes of the registered count, so they change one cycle after the accepted operation. Thresholds are compared live and may change at any time.
- Full with push & pop: both accepted; the RAM reads the old word at rd_ptr (== wr_ptr) before the edge overwrites it; count stays DEPTH.
- Empty with push & pop: pop rejected, push accepted; count becomes 1; error set (underflow).
- Overflow: push & full & ~pop → push ignored, pointers and count unchanged, error set.
- Underflow: pop & empty → pop ignored, error set.
- error stays 1 until reset.
- Invariant: wr_ptr − rd_ptr ≡ count (mod DEPTH), with count==DEPTH exactly when full.

Decomposition:
- Shared parameter include: default DATA_SIZE and MAIN_QUEUE_SIZE, shared by fifo_ctrl, the RAM and the queue wrapper so widths cannot diverge. No typedefs.
- One natural sub-module, fifo_ptr: a MAIN_QUEUE_SIZE-bit wrapping incrementer with enable and synchronous active-low reset. It is instantiated twice (write and read pointers).

Test Plan:
1. Reset then idle → wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, error=0; write=read=0 while reset_L=0.
2. Push 8 consecutive cycles (thr_almost_full=6) → wr_ptr 0..7 then back to 0; count=8; full=1 one cycle after the 8th push; almost_full=1 once count=6; error=0.
3. From full, push alone → write=0, count=8, error=1. Then push & pop together → write=1, read=1, count stays 8, rd_ptr=1, wr_ptr=1.
4. Drain to empty with pop, then one more pop → read=0, count=0, error stays/becomes 1. With thr_almost_empty=2, almost_empty=1 once count<=2.
5. From empty, push & pop in the same cycle → write=1, read=0, count=1, wr_ptr advances by 1, rd_ptr unchanged, error=1.
6. Assert reset_L=0 mid-stream (count=5) with push=1 → next edge: count=0, pointers 0, error=0, no RAM write.
